// File: rtl/alarm_pkg.sv
// Shared types, constants and BCD validation helpers for the alarm engine.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } alarm_state_t;

   localparam int unsigned BCD_W = 8;
   localparam logic [BCD_W-1:0] MIDNIGHT = 8'h00;

   function automatic logic bcd_hr_valid(input logic [BCD_W-1:0] v);
      return (v[7:4] <= 4'd2) && (v[3:0] <= 4'd9) && (v <= 8'h23);
   endfunction

   function automatic logic bcd_min_valid(input logic [BCD_W-1:0] v);
      return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored HH:MM, armed flag, ring/snooze FSM and its counters.
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [BCD_W-1:0] cur_hr,
   input  logic [BCD_W-1:0] cur_min,
   input  logic [BCD_W-1:0] cur_sec,
   input  logic             wr,
   input  logic [BCD_W-1:0] wr_hr,
   input  logic [BCD_W-1:0] wr_min,
   input  logic             wr_arm,
   input  logic             snooze,
   input  logic             dismiss,
   output logic             ring,
   output logic             snoozed
);

   localparam logic [7:0]  RING_LAST = 8'(RING_SECS - 1);
   localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_SECS);
   localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

   alarm_state_t     state;
   logic [BCD_W-1:0] alm_hr;
   logic [BCD_W-1:0] alm_min;
   logic             armed;
   logic [7:0]       ring_cnt;
   logic [15:0]      timer;
   logic [3:0]       snz_cnt;
   logic             hit;

   // Only the sec==00 tick qualifies, so setting the current minute mid-minute waits a day.
   assign hit = armed && (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == MIDNIGHT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         alm_hr   <= '0;
         alm_min  <= '0;
         armed    <= 1'b0;
         ring_cnt <= '0;
         timer    <= '0;
         snz_cnt  <= '0;
         ring     <= 1'b0;
         snoozed  <= 1'b0;
      end else if (wr) begin
         state    <= IDLE;
         alm_hr   <= wr_hr;
         alm_min  <= wr_min;
         armed    <= wr_arm;
         ring_cnt <= '0;
         timer    <= '0;
         snz_cnt  <= '0;
         ring     <= 1'b0;
         snoozed  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (tick && hit) begin
                  state    <= RINGING;
                  ring_cnt <= '0;
                  snz_cnt  <= '0;
                  ring     <= 1'b1;
               end
            end
            RINGING: begin
               if (dismiss) begin
                  state   <= IDLE;
                  snz_cnt <= '0;
                  ring    <= 1'b0;
               end else if (snooze) begin
                  ring <= 1'b0;
                  if (snz_cnt < SNZ_MAX) begin
                     state   <= SNOOZED;
                     timer   <= SNZ_LOAD;
                     snz_cnt <= snz_cnt + 4'd1;
                     snoozed <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     snz_cnt <= '0;
                  end
               end else if (tick) begin
                  ring_cnt <= ring_cnt + 8'd1;
                  if (ring_cnt == RING_LAST) begin
                     state   <= IDLE;
                     snz_cnt <= '0;
                     ring    <= 1'b0;
                  end
               end
            end
            SNOOZED: begin
               if (dismiss) begin
                  state   <= IDLE;
                  snz_cnt <= '0;
                  snoozed <= 1'b0;
               end else if (tick) begin
                  timer <= timer - 16'd1;
                  if (timer == 16'd1) begin
                     state    <= RINGING;
                     ring_cnt <= '0;
                     ring     <= 1'b1;
                     snoozed  <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ring    <= 1'b0;
               snoozed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alarm_bank.sv
// Multi-alarm engine: write decode/validation, per-channel FSMs, ring summary.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS  = 3,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3,
   localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic [7:0]            cur_hr,
   input  logic [7:0]            cur_min,
   input  logic [7:0]            cur_sec,
   input  logic                  set_en,
   input  logic [IDX_W-1:0]      set_idx,
   input  logic [7:0]            set_hr,
   input  logic [7:0]            set_min,
   input  logic                  set_arm,
   input  logic                  snooze,
   input  logic                  dismiss,
   output logic [NUM_ALARMS-1:0] ring,
   output logic                  any_ring,
   output logic [NUM_ALARMS-1:0] snoozed,
   output logic                  set_err
);

   logic idx_ok;
   logic wr_ok;

   assign idx_ok = int'(set_idx) < NUM_ALARMS;
   assign wr_ok  = set_en && idx_ok && bcd_hr_valid(set_hr) && bcd_min_valid(set_min);

   always_ff @(posedge clk) begin
      if (rst) set_err <= 1'b0;
      else     set_err <= set_en && !wr_ok;
   end

   // ring is already a flop per channel, so the OR adds no extra latency.
   assign any_ring = |ring;

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
      alarm_channel #(
         .RING_SECS   (RING_SECS),
         .SNOOZE_SECS (SNOOZE_SECS),
         .MAX_SNOOZE  (MAX_SNOOZE)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .tick    (tick),
         .cur_hr  (cur_hr),
         .cur_min (cur_min),
         .cur_sec (cur_sec),
         .wr      (wr_ok && (set_idx == IDX_W'(i))),
         .wr_hr   (set_hr),
         .wr_min  (set_min),
         .wr_arm  (set_arm),
         .snooze  (snooze),
         .dismiss (dismiss),
         .ring    (ring[i]),
         .snoozed (snoozed[i])
      );
   end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed scoreboard bench for alarm_bank with default parameters.
module tb_alarm_bank;

   localparam int N    = 3;
   localparam int RING = 60;
   localparam int SNZ  = 300;
   localparam int MAXS = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] cur_hr = '0, cur_min = '0, cur_sec = '0;
   logic       set_en = 1'b0;
   logic [1:0] set_idx = '0;
   logic [7:0] set_hr = '0, set_min = '0;
   logic       set_arm = 1'b0;
   logic       snooze = 1'b0;
   logic       dismiss = 1'b0;
   logic [N-1:0] ring, snoozed;
   logic       any_ring, set_err;

   alarm_bank #(
      .NUM_ALARMS  (N),
      .RING_SECS   (RING),
      .SNOOZE_SECS (SNZ),
      .MAX_SNOOZE  (MAXS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .cur_hr   (cur_hr),
      .cur_min  (cur_min),
      .cur_sec  (cur_sec),
      .set_en   (set_en),
      .set_idx  (set_idx),
      .set_hr   (set_hr),
      .set_min  (set_min),
      .set_arm  (set_arm),
      .snooze   (snooze),
      .dismiss  (dismiss),
      .ring     (ring),
      .any_ring (any_ring),
      .snoozed  (snoozed),
      .set_err  (set_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] r;
      logic [2:0] s;
      logic       a;
      logic       e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic step(input string tag, input logic [2:0] r, input logic [2:0] s, input logic e);
      exp_t x;
      x.tag = tag; x.r = r; x.s = s; x.a = |r; x.e = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
      tick = 1'b0; set_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
      x = sb.pop_front();
      checks++;
      assert ({ring, snoozed, any_ring, set_err} === {x.r, x.s, x.a, x.e}) else begin
         errors++;
         $error("FAIL %s: observed ring=%b snoozed=%b any=%b err=%b, expected ring=%b snoozed=%b any=%b err=%b",
                x.tag, ring, snoozed, any_ring, set_err, x.r, x.s, x.a, x.e);
      end
   endtask

   task automatic tick_at(input int h, input int m, input int s);
      cur_hr = bcd(h); cur_min = bcd(m); cur_sec = bcd(s);
      tick = 1'b1;
   endtask

   task automatic write(input int idx, input logic [7:0] h, input logic [7:0] m, input logic arm);
      set_en = 1'b1; set_idx = 2'(idx); set_hr = h; set_min = m; set_arm = arm;
   endtask

   task automatic quiet_ticks(input string tag, input int n, input logic [2:0] r, input logic [2:0] s);
      for (int i = 0; i < n; i++) begin
         tick_at(12, 34, 56);
         step(tag, r, s, 1'b0);
      end
   endtask

   initial begin
      step("reset", 3'b000, 3'b000, 1'b0);
      rst = 1'b0;

      // Basic fire and auto-stop on channel 0.
      write(0, 8'h06, 8'h30, 1'b1);
      step("wr0", 3'b000, 3'b000, 1'b0);
      tick_at(6, 29, 59);
      step("pre_fire", 3'b000, 3'b000, 1'b0);
      tick_at(6, 30, 0);
      step("fire0", 3'b001, 3'b000, 1'b0);
      step("no_tick_hold", 3'b001, 3'b000, 1'b0);
      quiet_ticks("ringing0", RING - 1, 3'b001, 3'b000);
      quiet_ticks("autostop0", 1, 3'b000, 3'b000);

      // Snooze cycling on channel 1, then exhaustion.
      write(1, 8'h07, 8'h00, 1'b1);
      step("wr1", 3'b000, 3'b000, 1'b0);
      tick_at(7, 0, 0);
      step("fire1", 3'b010, 3'b000, 1'b0);
      for (int k = 0; k < MAXS; k++) begin
         snooze = 1'b1;
         step("snooze1", 3'b000, 3'b010, 1'b0);
         quiet_ticks("snoozed1", SNZ - 1, 3'b000, 3'b010);
         quiet_ticks("rering1", 1, 3'b010, 3'b000);
      end
      snooze = 1'b1;
      step("snooze_max", 3'b000, 3'b000, 1'b0);
      quiet_ticks("after_max", 2, 3'b000, 3'b000);

      // Two channels together, dismiss, fire again next day.
      write(0, 8'h23, 8'h50, 1'b1);
      step("wr0b", 3'b000, 3'b000, 1'b0);
      write(2, 8'h23, 8'h50, 1'b1);
      step("wr2", 3'b000, 3'b000, 1'b0);
      tick_at(23, 50, 0);
      step("fire02", 3'b101, 3'b000, 1'b0);
      dismiss = 1'b1;
      step("dismiss02", 3'b000, 3'b000, 1'b0);
      quiet_ticks("post_dismiss", 3, 3'b000, 3'b000);
      tick_at(23, 50, 0);
      step("fire02_day2", 3'b101, 3'b000, 1'b0);
      dismiss = 1'b1;
      snooze = 1'b1;
      step("dismiss_over_snooze", 3'b000, 3'b000, 1'b0);

      // Rejected writes leave stored times unchanged.
      write(0, 8'h24, 8'h10, 1'b1);
      step("err_hr24", 3'b000, 3'b000, 1'b1);
      step("err_clear", 3'b000, 3'b000, 1'b0);
      write(0, 8'h10, 8'h60, 1'b1);
      step("err_min60", 3'b000, 3'b000, 1'b1);
      write(0, 8'h1A, 8'h10, 1'b1);
      step("err_hr1a", 3'b000, 3'b000, 1'b1);
      write(3, 8'h01, 8'h00, 1'b0);
      step("err_idx3", 3'b000, 3'b000, 1'b1);
      step("err_clear2", 3'b000, 3'b000, 1'b0);
      tick_at(23, 50, 0);
      step("unchanged02", 3'b101, 3'b000, 1'b0);
      dismiss = 1'b1;
      step("dismiss_c", 3'b000, 3'b000, 1'b0);
      tick_at(7, 0, 0);
      step("unchanged1", 3'b010, 3'b000, 1'b0);
      dismiss = 1'b1;
      step("dismiss_d", 3'b000, 3'b000, 1'b0);

      // A write on the matching tick suppresses that channel's trigger.
      tick_at(23, 50, 0);
      write(2, 8'h23, 8'h50, 1'b1);
      step("overlap", 3'b001, 3'b000, 1'b0);
      dismiss = 1'b1;
      step("dismiss_e", 3'b000, 3'b000, 1'b0);

      // Setting the current minute mid-minute does not fire.
      cur_hr = 8'h23; cur_min = 8'h50; cur_sec = 8'h30;
      write(1, 8'h23, 8'h50, 1'b1);
      step("wr_mid", 3'b000, 3'b000, 1'b0);
      tick_at(23, 50, 31);
      step("mid_minute", 3'b000, 3'b000, 1'b0);

      // Reset while ringing.
      tick_at(23, 50, 0);
      step("fire_all", 3'b111, 3'b000, 1'b0);
      rst = 1'b1;
      step("mid_ring_rst", 3'b000, 3'b000, 1'b0);
      rst = 1'b0;
      tick_at(0, 0, 0);
      step("midnight_disarmed", 3'b000, 3'b000, 1'b0);
      tick_at(23, 50, 0);
      step("cleared_time", 3'b000, 3'b000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised multi-alarm engine; successor to the fixed three-alarm logic inside the clock top level.
- Holds NUM_ALARMS programmable HH:MM alarms in BCD and compares them against the running time-of-day counter on each 1 Hz tick.
- Drives per-alarm ring outputs with auto-timeout, snooze with a bounded repeat count, and global dismiss.
- Sits between the time counter and the display/buzzer logic.

Parameters:
- NUM_ALARMS, 3, number of independent alarm channels (1..16).
- RING_SECS, 60, ticks a channel rings before auto-stopping (1..255).
- SNOOZE_SECS, 300, ticks a channel stays snoozed before re-ringing (1..65535).
- MAX_SNOOZE, 3, snoozes allowed per trigger; one more snooze acts as dismiss (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz enable, aligned with time counter update.
- cur_hr  in  8  current hours, BCD {tens,ones}, 00..23.
- cur_min  in  8  current minutes, BCD, 00..59.
- cur_sec  in  8  current seconds, BCD, 00..59.
- set_en  in  1  write strobe for one alarm.
- set_idx  in  IDX_W  target channel; IDX_W = max(1, clog2(NUM_ALARMS)).
- set_hr  in  8  alarm hour, BCD.
- set_min  in  8  alarm minute, BCD.
- set_arm  in  1  armed flag written with the time.
- snooze  in  1  one-cycle pulse; applies to all ringing channels.
- dismiss  in  1  one-cycle pulse; applies to all ringing or snoozed channels.
- ring  out  NUM_ALARMS  per-channel ringing flag.
- any_ring  out  1  OR of ring.
- snoozed  out  NUM_ALARMS  per-channel snoozed flag.
- set_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous, active-high.
- Reset clears all alarm times to 00:00, armed=0, state IDLE, counters 0, snooze counts 0. Outputs ring=0, snoozed=0, any_ring=0, set_err=0.
- Per-channel FSM: IDLE, RINGING, SNOOZED.
- IDLE -> RINGING:
  - Condition: tick=1 and armed and cur_hr==alm_hr and cur_min==alm_min and cur_sec==8'h00.
  - ring asserts the cycle after the qualifying tick.
  - ring_cnt and snooze_cnt load 0.
- RINGING:
  - ring_cnt increments on each tick.
  - When it reaches RING_SECS: -> IDLE and snooze_cnt cleared (auto-stop).
- RINGING + snooze pulse:
  - If snooze_cnt < MAX_SNOOZE: -> SNOOZED, timer loads SNOOZE_SECS, snooze_cnt++.
  - Otherwise: -> IDLE (acts as dismiss).
- SNOOZED:
  - Timer decrements on tick.
  - On the tick that reaches 0: -> RINGING, ring_cnt=0.
  - Re-ring does not require a time match.
- Dismiss: any RINGING or SNOOZED -> IDLE, snooze_cnt=0. The alarm stays armed and fires again the next day.
- Priority within a cycle: rst > set write to that channel > dismiss > snooze > tick-driven events.
- Write:
  - Validation: set_hr tens<=2, ones<=9, value<=0x23; set_min tens<=5, ones<=9.
  - Invalid data: write ignored, set_err pulses the next cycle.
  - set_idx >= NUM_ALARMS: write ignored, set_err pulses.
  - Valid write: updates time/armed, forces the channel to IDLE, clears its counters. Takes effect the next cycle.
- Write/trigger overlap: a write landing on the same cycle as a matching tick suppresses that trigger.
- Trigger is edge-like: it fires only on the sec==00 tick, so an alarm set to the current minute mid-minute does not fire until the next day.
- Channels are fully independent; several may ring simultaneously.
- Counter widths: ring_cnt 8 bits; snooze timer 16 bits; snooze_cnt 4 bits.
- Outputs are registered; latency is 1 cycle from the qualifying input.
- Mid-ring reset returns everything to reset values in the next cycle.

Decomposition:
- alarm_pkg:
  - State encoding (IDLE=2'd0, RINGING=2'd1, SNOOZED=2'd2).
  - BCD width constant (8).
  - BCD-valid function for hours and minutes.
  - Midnight constant 8'h00.
- Sub-module alarm_channel: one FSM, its counters, stored time and comparator. It is instantiated NUM_ALARMS times via generate.
- Top level holds write decode/validation, set_err, any_ring reduction.

Test Plan:
- Write idx0 = 06:30 armed; drive ticks through 06:29:59 -> 06:30:00 -> ring[0]=1 one cycle after that tick; ring[0]=0 after 60 further ticks with RING_SECS=60.
- Ringing ch1 (alarm 07:00) with snooze pulse -> snoozed[1]=1, ring[1]=0; ring[1]=1 after 300 ticks. The fourth snooze with MAX_SNOOZE=3 -> IDLE, ring[1]=0, snoozed[1]=0.
- ch0 and ch2 both set to 23:50, both armed -> both ring together. Dismiss -> ring=3'b000, any_ring=0. Both fire again at 23:50:00 of the next simulated day.
- Write set_hr=8'h24, then set_min=8'h60, then set_hr=8'h1A -> each pulses set_err for one cycle; the stored alarm is unchanged.
- set_idx=3 with NUM_ALARMS=3 -> set_err pulse, no channel changes.
- ch0 ringing, then rst=1 for one cycle -> ring=0, alarm time 00:00, disarmed. No ring at a subsequent 00:00:00 tick.
